pulse_train_gen: RTL and testbench
==================================

Name: pulse_train_gen

Overview:
Transmit-side counterpart of the posedge-enabled edge counter. On request, it emits a train of exactly N clean rectangular pulses on a single line, with programmable high and low widths. The receiving edge counter at the far end therefore increments exactly N times. Used in the uart_radio datapath to generate strobes and bit-tick bursts, and as a loopback stimulus for the counter.

Parameters:
CNT_W, 4, width of the pulse-count request and the sent-pulse counter (max train length 2^CNT_W-1).
HIGH_CYC, 1, clock cycles each pulse stays high (must be >= 1).
LOW_CYC, 1, clock cycles of low gap after each pulse, including the last one (must be >= 1).

Ports:
clk  in  1  system clock, all logic on rising edge.
kill  in  1  asynchronous, active-high reset.
start  in  1  train request, sampled only in IDLE.
num  in  CNT_W  number of pulses; latched when start is accepted.
pulse  out  1  the pulse-train line (registered).
busy  out  1  high while a train is in progress.
done  out  1  single-cycle completion strobe.
sent  out  CNT_W  pulses completed in the current or last train.

Behaviour:
- Reset: kill asynchronously forces pulse=0, busy=0, done=0, sent=0, state=IDLE and clears the phase timer, regardless of clock.
- All outputs are registered; no combinational path from any input to any output.
- States:
  - IDLE: waiting for a request.
  - HIGH: pulse=1, timer counts HIGH_CYC cycles.
  - LOW: pulse=0, timer counts LOW_CYC cycles.
  - FIN: one cycle with done=1, then IDLE.
- IDLE, start=1 at edge k, num>0: latch num, clear sent, enter HIGH. At edge k, pulse=1 and busy=1.
- IDLE, start=1, num=0: go directly to FIN. done=1 for the cycle after edge k; busy and pulse stay 0; sent is cleared to 0.
- HIGH -> LOW after HIGH_CYC cycles. At the same edge, pulse=0 and sent increments by 1.
- LOW after LOW_CYC cycles:
  - if sent != latched num: go to HIGH (pulse=1);
  - else: go to FIN (busy=0, done=1).
- FIN -> IDLE on the next edge; done returns to 0.
- Timing for num=N: busy is high for exactly N*(HIGH_CYC+LOW_CYC) cycles. done rises at edge k+N*(HIGH_CYC+LOW_CYC).
- The trailing LOW gap is always emitted, so a receiver sampling at the same clock sees a low before any following train.
- start when not in IDLE (HIGH, LOW, FIN) is ignored. No queuing; num changes during a train have no effect.
- A start held high is accepted again on the first IDLE cycle, i.e. one cycle after done.
- sent holds its final value after done until the next accepted start. It never wraps, since it is bounded by num <= 2^CNT_W-1.
- Phase timer: loads HIGH_CYC-1 or LOW_CYC-1 and counts down to 0. Its width is clog2(max(HIGH_CYC,LOW_CYC))+1. The expiry flag is its count being 0.
- kill asserted mid-train aborts immediately:
  - pulse drops asynchronously;
  - no done is generated;
  - a new train requires start after kill is released.

Decomposition:
- Shared package/include holds:
  - state encoding constants (IDLE, HIGH, LOW, FIN, 2 bits);
  - a clog2 function for timer width;
  - the parameter legality check (HIGH_CYC, LOW_CYC >= 1).
- One natural sub-module: pulse_phase_timer. It is a loadable down-counter with async kill, inputs load/load_val, output expired. The top module holds the FSM, the num latch and the sent counter.

Test Plan:
- HIGH_CYC=2, LOW_CYC=3, start at edge k with num=3 -> pulse high on cycles k..k+1, k+5..k+6, k+10..k+11; busy for 15 cycles; done=1 only at k+15; sent=3. A loopback edge counter reads 3.
- num=0 with start -> done=1 for exactly one cycle after the accepting edge; pulse never high; busy never high; sent=0.
- Defaults (1/1), num=15 -> 15 alternating high/low pulses; done at k+30; sent=15; no wrap to 0.
- start re-asserted with num=7 while busy on a num=2 train -> only 2 pulses; sent=2. Start held continuously -> the next train is accepted at the edge after done, with one idle cycle between.
- kill pulsed asynchronously mid-HIGH of pulse 2 of num=5 -> pulse, busy and sent go to 0 before the next clock edge; no done; a following start with num=1 yields exactly one pulse.

Source files
------------

// File: rtl/pulse_train_gen_pkg.sv
// Shared types and elaboration helpers for the pulse train generator.
// No logic; state encoding, timer sizing and parameter legality check.
// Imported by the top module.
package pulse_train_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Phase timer width: enough to hold max(HIGH_CYC, LOW_CYC)-1 with one bit of margin.
  function automatic int timer_w(input int high_cyc, input int low_cyc);
    return clog2((high_cyc > low_cyc) ? high_cyc : low_cyc) + 1;
  endfunction

  // Both phases must last at least one clock.
  function automatic bit params_ok(input int high_cyc, input int low_cyc);
    return (high_cyc >= 1) && (low_cyc >= 1);
  endfunction

endpackage

// File: rtl/pulse_phase_timer.sv
// Loadable down-counter timing the HIGH and LOW phases of each pulse.
// Latency: load takes effect at the next edge; expired is a registered-count compare.
// No backpressure; counts down to 0 and holds there until reloaded.
module pulse_phase_timer #(
  parameter int TW = 1
) (
  input  logic          clk,
  input  logic          kill,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          expired
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Next count: reload on request, otherwise decrement and saturate at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register, cleared asynchronously by kill.
  always_ff @(posedge clk or posedge kill) begin
    if (kill) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Emits a train of num rectangular pulses (HIGH_CYC high, LOW_CYC low each) on request.
// Latency: pulse rises at the accepting edge; done at N*(HIGH_CYC+LOW_CYC) edges later.
// No backpressure; start is only sampled in IDLE, ignored while a train runs.
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int HIGH_CYC = 1,
  parameter int LOW_CYC  = 1
) (
  input  logic             clk,
  input  logic             kill,
  input  logic             start,
  input  logic [CNT_W-1:0] num,
  output logic             pulse,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent
);

  localparam int TW = timer_w(HIGH_CYC, LOW_CYC);
  localparam logic [TW-1:0] HIGH_LD = TW'(HIGH_CYC - 1);
  localparam logic [TW-1:0] LOW_LD  = TW'(LOW_CYC - 1);

  generate
    if (!params_ok(HIGH_CYC, LOW_CYC)) begin : g_bad_params
      $error("pulse_train_gen: HIGH_CYC and LOW_CYC must both be >= 1");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             tmr_expired;

  pulse_phase_timer #(
    .TW(TW)
  ) u_phase_timer (
    .clk      (clk),
    .kill     (kill),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  // Next-state and next-output logic; outputs are computed one edge ahead so they leave as flops.
  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    sent_d   = sent_q;
    pulse_d  = pulse_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = HIGH_LD;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_d    = num;
          sent_d   = '0;
          tmr_load = 1'b1;
          tmr_val  = HIGH_LD;
          if (num != '0) begin
            state_d = ST_HIGH;
            pulse_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            // Empty request still completes with a done strobe.
            state_d = ST_FIN;
            done_d  = 1'b1;
          end
        end
      end
      ST_HIGH: begin
        if (tmr_expired) begin
          state_d  = ST_LOW;
          pulse_d  = 1'b0;
          sent_d   = sent_q + 1'b1;
          tmr_load = 1'b1;
          tmr_val  = LOW_LD;
        end
      end
      ST_LOW: begin
        // Trailing low gap is always completed before finishing.
        if (tmr_expired) begin
          if (sent_q != num_q) begin
            state_d  = ST_HIGH;
            pulse_d  = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = HIGH_LD;
          end else begin
            state_d = ST_FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; kill aborts the train with no done.
  always_ff @(posedge clk or posedge kill) begin
    if (kill) begin
      state_q <= ST_IDLE;
      num_q   <= '0;
      sent_q  <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      sent_q  <= sent_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pulse = pulse_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sent  = sent_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
`timescale 1ns/1ps
module tb_pulse_train_gen;

  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: HIGH_CYC=2, LOW_CYC=3. Instance B: defaults 1/1.
  logic          kill_a = 1'b1, start_a = 1'b0;
  logic [CW-1:0] num_a = '0;
  logic          pulse_a, busy_a, done_a;
  logic [CW-1:0] sent_a;
  logic          kill_b = 1'b1, start_b = 1'b0;
  logic [CW-1:0] num_b = '0;
  logic          pulse_b, busy_b, done_b;
  logic [CW-1:0] sent_b;

  pulse_train_gen #(.CNT_W(CW), .HIGH_CYC(2), .LOW_CYC(3)) u_dut_a (
    .clk(clk), .kill(kill_a), .start(start_a), .num(num_a),
    .pulse(pulse_a), .busy(busy_a), .done(done_a), .sent(sent_a)
  );

  pulse_train_gen #(.CNT_W(CW), .HIGH_CYC(1), .LOW_CYC(1)) u_dut_b (
    .clk(clk), .kill(kill_b), .start(start_b), .num(num_b),
    .pulse(pulse_b), .busy(busy_b), .done(done_b), .sent(sent_b)
  );

  typedef struct packed {
    logic          pulse;
    logic          busy;
    logic          done;
    logic [CW-1:0] sent;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic obs_t obs_a();
    obs_t o;
    o.pulse = pulse_a; o.busy = busy_a; o.done = done_a; o.sent = sent_a;
    return o;
  endfunction

  function automatic obs_t obs_b();
    obs_t o;
    o.pulse = pulse_b; o.busy = busy_b; o.done = done_b; o.sent = sent_b;
    return o;
  endfunction

  // Reference trace of one train, one entry per cycle starting with the sample after the
  // accepting edge, ending with the done cycle and the following idle cycle.
  task automatic push_train(input int h, input int l, input int n);
    int   p;
    obs_t e;
    p = h + l;
    for (int i = 0; i < n * p; i++) begin
      e.pulse = ((i % p) < h);
      e.busy  = 1'b1;
      e.done  = 1'b0;
      e.sent  = CW'((i / p) + (((i % p) >= h) ? 1 : 0));
      exp_q.push_back(e);
    end
    e.pulse = 1'b0; e.busy = 1'b0; e.done = 1'b1; e.sent = CW'(n);
    exp_q.push_back(e);
    e.done = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    obs_t got;
    #1;
    got = obs_a();
    n_checks++;
    if (got !== '0) $display("FAIL reset_async_a got %b want %b", got, obs_t'(0));
    else n_pass++;
    got = obs_b();
    n_checks++;
    if (got !== '0) $display("FAIL reset_async_b got %b want %b", got, obs_t'(0));
    else n_pass++;
    repeat (2) @(negedge clk);
    start_a = 1'b1; num_a = 4'd3;
    @(negedge clk);
    got = obs_a();
    n_checks++;
    if (got !== '0) $display("FAIL reset_held_a got %b want %b", got, obs_t'(0));
    else n_pass++;
    start_a = 1'b0;
    kill_a = 1'b0; kill_b = 1'b0;
    @(negedge clk);
    got = obs_b();
    n_checks++;
    if (got !== '0) $display("FAIL reset_idle_b got %b want %b", got, obs_t'(0));
    else n_pass++;
  endtask

  task automatic test_train_a();
    obs_t got, exp;
    int   cyc, edges;
    logic prev;
    cyc = 0; edges = 0; prev = 1'b0;
    @(negedge clk);
    start_a = 1'b1; num_a = 4'd3;
    push_train(2, 3, 3);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      start_a = 1'b0;
      got = obs_a(); exp = exp_q.pop_front();
      if (got.pulse && !prev) edges++;
      prev = got.pulse;
      n_checks++;
      if (got !== exp)
        $display("FAIL train_n3 cyc%0d got p=%b b=%b d=%b s=%0d want p=%b b=%b d=%b s=%0d",
                 cyc, got.pulse, got.busy, got.done, got.sent, exp.pulse, exp.busy, exp.done, exp.sent);
      else n_pass++;
      cyc++;
    end
    n_checks++;
    if (edges !== 3) $display("FAIL train_n3_edges got %0d want 3", edges);
    else n_pass++;
  endtask

  task automatic test_zero_num();
    obs_t got, exp;
    int   cyc;
    cyc = 0;
    @(negedge clk);
    start_a = 1'b1; num_a = 4'd0;
    push_train(2, 3, 0);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      start_a = 1'b0;
      got = obs_a(); exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp)
        $display("FAIL zero_num cyc%0d got p=%b b=%b d=%b s=%0d want p=%b b=%b d=%b s=%0d",
                 cyc, got.pulse, got.busy, got.done, got.sent, exp.pulse, exp.busy, exp.done, exp.sent);
      else n_pass++;
      cyc++;
    end
  endtask

  task automatic test_max_count();
    obs_t got, exp;
    int   cyc, edges;
    logic prev;
    cyc = 0; edges = 0; prev = 1'b0;
    @(negedge clk);
    start_b = 1'b1; num_b = 4'd15;
    push_train(1, 1, 15);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      start_b = 1'b0;
      got = obs_b(); exp = exp_q.pop_front();
      if (got.pulse && !prev) edges++;
      prev = got.pulse;
      n_checks++;
      if (got !== exp)
        $display("FAIL max_n15 cyc%0d got p=%b b=%b d=%b s=%0d want p=%b b=%b d=%b s=%0d",
                 cyc, got.pulse, got.busy, got.done, got.sent, exp.pulse, exp.busy, exp.done, exp.sent);
      else n_pass++;
      cyc++;
    end
    n_checks++;
    if (edges !== 15) $display("FAIL max_n15_edges got %0d want 15", edges);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    obs_t got, exp;
    int   cyc, edges;
    logic prev;
    cyc = 0; edges = 0; prev = 1'b0;
    @(negedge clk);
    start_a = 1'b1; num_a = 4'd2;
    // Start stays high: num=7 must be ignored mid-train, then accepted after the idle cycle.
    push_train(2, 3, 2);
    push_train(2, 3, 7);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      got = obs_a(); exp = exp_q.pop_front();
      if (got.pulse && !prev) edges++;
      prev = got.pulse;
      n_checks++;
      if (got !== exp)
        $display("FAIL back_to_back cyc%0d got p=%b b=%b d=%b s=%0d want p=%b b=%b d=%b s=%0d",
                 cyc, got.pulse, got.busy, got.done, got.sent, exp.pulse, exp.busy, exp.done, exp.sent);
      else n_pass++;
      if (cyc == 0) num_a = 4'd7;
      if (cyc == 12) start_a = 1'b0;
      cyc++;
    end
    n_checks++;
    if (edges !== 9) $display("FAIL back_to_back_edges got %0d want 9", edges);
    else n_pass++;
  endtask

  task automatic test_kill_mid();
    obs_t got, exp;
    int   cyc, edges;
    logic prev;
    cyc = 0;
    @(negedge clk);
    start_a = 1'b1; num_a = 4'd5;
    push_train(2, 3, 5);
    // Run up to the first high cycle of pulse 2.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start_a = 1'b0;
      got = obs_a(); exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp)
        $display("FAIL kill_pre cyc%0d got p=%b b=%b d=%b s=%0d want p=%b b=%b d=%b s=%0d",
                 i, got.pulse, got.busy, got.done, got.sent, exp.pulse, exp.busy, exp.done, exp.sent);
      else n_pass++;
    end
    exp_q.delete();
    #2 kill_a = 1'b1;
    #1 got = obs_a();
    n_checks++;
    if (got !== '0) $display("FAIL kill_async got %b want %b", got, obs_t'(0));
    else n_pass++;
    #1 kill_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      got = obs_a();
      n_checks++;
      if (got !== '0) $display("FAIL kill_quiet cyc%0d got %b want %b", i, got, obs_t'(0));
      else n_pass++;
    end
    edges = 0; prev = 1'b0;
    @(negedge clk);
    start_a = 1'b1; num_a = 4'd1;
    push_train(2, 3, 1);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      start_a = 1'b0;
      got = obs_a(); exp = exp_q.pop_front();
      if (got.pulse && !prev) edges++;
      prev = got.pulse;
      n_checks++;
      if (got !== exp)
        $display("FAIL kill_after cyc%0d got p=%b b=%b d=%b s=%0d want p=%b b=%b d=%b s=%0d",
                 cyc, got.pulse, got.busy, got.done, got.sent, exp.pulse, exp.busy, exp.done, exp.sent);
      else n_pass++;
      cyc++;
    end
    n_checks++;
    if (edges !== 1) $display("FAIL kill_after_edges got %0d want 1", edges);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_train_a();
    test_zero_num();
    test_max_count();
    test_back_to_back();
    test_kill_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
